// File: rtl/ins_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ins_fetch
//  Brief    : Instruction-fetch initiator. Holds the program counter, issues a
//             one-cycle request to the instruction ram, waits for its
//             registered acknowledge, latches the returned instruction and
//             presents it with a one-cycle valid pulse. Jumps may arrive at
//             any time; those arriving mid-fetch are held until the fetch ends.
//  Revision : 1.0  initial release
// ============================================================================
module ins_fetch #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RST_PC   = 0,
  parameter int MAX_ADDR = 10,
  parameter int TIMEOUT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  input  logic          en_ram_out,
  input  logic [DW-1:0] ins_in,
  output logic [AW-1:0] addr,
  output logic          en_ram_in,
  output logic [DW-1:0] ins,
  output logic          en_out,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          err
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int            CW         = $clog2(TIMEOUT);
  localparam logic [AW-1:0] C_RST_PC   = AW'(RST_PC);
  localparam logic [AW-1:0] C_MAX_ADDR = AW'(MAX_ADDR);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic [AW-1:0] r_pend_addr;

  logic          w_pend_hit;
  logic [AW-1:0] w_pend_target;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_next;
  logic [AW-1:0] w_next_err;

  // A jump strobe on the very edge that ends a fetch counts as pending, so the
  // live strobe takes priority over (and overrides) any stored jump target.
  assign w_pend_hit    = r_pending | jmp_en;
  assign w_pend_target = jmp_en ? jmp_addr : r_pend_addr;
  // Sequential increment wraps at MAX_ADDR; targets above MAX_ADDR also wrap.
  assign w_pc_inc      = (pc >= C_MAX_ADDR) ? '0 : (pc + AW'(1));
  assign w_next        = w_pend_hit ? w_pend_target : w_pc_inc;
  // On timeout the failed address is kept so the next request retries it.
  assign w_next_err    = w_pend_hit ? w_pend_target : pc;

  // Busy whenever a fetch is in flight.
  assign busy = (r_state != S_IDLE);

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
      pc          <= C_RST_PC;
      addr        <= C_RST_PC;
      en_ram_in   <= 1'b0;
      ins         <= '0;
      en_out      <= 1'b0;
      err         <= 1'b0;
    end else begin
      en_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          en_ram_in <= 1'b0;
          if (jmp_en) begin
            pc <= jmp_addr;
          end
          if (en_in) begin
            addr      <= jmp_en ? jmp_addr : pc;
            en_ram_in <= 1'b1;
            err       <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          en_ram_in <= 1'b0;
          r_cnt     <= '0;
          if (jmp_en) begin
            r_pending   <= 1'b1;
            r_pend_addr <= jmp_addr;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (en_ram_out) begin
            ins       <= ins_in;
            en_out    <= 1'b1;
            pc        <= w_next;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            err       <= 1'b1;
            pc        <= w_next_err;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (jmp_en) begin
              r_pending   <= 1'b1;
              r_pend_addr <= jmp_addr;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ins_fetch
//  Brief    : Directed self-checking bench for ins_fetch with a simple
//             registered ram model of programmable acknowledge delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0;
  logic        jmp_en = 1'b0;
  logic [15:0] jmp_addr = '0;
  logic        en_ram_out;
  logic [15:0] ins_in;
  logic [15:0] addr;
  logic        en_ram_in;
  logic [15:0] ins;
  logic        en_out;
  logic [15:0] pc;
  logic        busy;
  logic        err;

  int vectors    = 0;
  int miscompares = 0;

  // Ram model controls
  logic        ram_on    = 1'b1;
  int          ram_delay = 0;
  logic        spur      = 1'b0;
  logic        ram_ack   = 1'b0;
  logic [15:0] ram_data  = '0;
  logic [15:0] lat_addr  = '0;
  int          pend_cnt  = 0;

  assign en_ram_out = ram_ack | spur;
  assign ins_in     = ram_data;

  ins_fetch #(.AW(16), .DW(16), .RST_PC(0), .MAX_ADDR(10), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .en_ram_out(en_ram_out), .ins_in(ins_in), .addr(addr), .en_ram_in(en_ram_in),
    .ins(ins), .en_out(en_out), .pc(pc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    return 16'hC3A5 ^ (a * 16'h1111);
  endfunction

  // Registered ram: acknowledges ram_delay cycles after sampling a request.
  always @(posedge clk) begin
    ram_ack <= 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        ram_ack  <= 1'b1;
        ram_data <= ram_val(lat_addr);
      end
    end
    if (en_ram_in && ram_on) begin
      lat_addr <= addr;
      if (ram_delay == 0) begin
        ram_ack  <= 1'b1;
        ram_data <= ram_val(addr);
      end else begin
        pend_cnt <= ram_delay;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    vectors++; if (pc !== 16'd0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 16'd0); end
    vectors++; if (addr !== 16'd0) begin miscompares++; $display("FAIL reset_addr: got %h want %h", addr, 16'd0); end
    vectors++; if ({en_ram_in, en_out, busy, err} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {en_ram_in, en_out, busy, err}); end
    vectors++; if (ins !== 16'd0) begin miscompares++; $display("FAIL reset_ins: got %h want %h", ins, 16'd0); end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // en_in held high: addresses 0..10 then wrap to 0, one instruction every 3 cycles.
  task automatic test_sequential();
    logic [15:0] exp_addr;
    logic [15:0] exp_next;
    exp_addr = 16'd0;
    ram_delay = 0;
    en_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_next = (exp_addr >= 16'd10) ? 16'd0 : exp_addr + 16'd1;
      tick();
      vectors++; if ({en_ram_in, en_out, busy} !== 3'b101) begin miscompares++; $display("FAIL seq_req_flags[%0d]: got %b want 101", k, {en_ram_in, en_out, busy}); end
      vectors++; if (addr !== exp_addr) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h want %h", k, addr, exp_addr); end
      tick();
      vectors++; if ({en_ram_in, en_out, busy} !== 3'b001) begin miscompares++; $display("FAIL seq_wait_flags[%0d]: got %b want 001", k, {en_ram_in, en_out, busy}); end
      tick();
      vectors++; if ({en_out, busy} !== 2'b10) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b want 10", k, {en_out, busy}); end
      vectors++; if (ins !== ram_val(exp_addr)) begin miscompares++; $display("FAIL seq_ins[%0d]: got %h want %h", k, ins, ram_val(exp_addr)); end
      vectors++; if (pc !== exp_next) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc, exp_next); end
      if (k == 11) en_in = 1'b0;
      exp_addr = exp_next;
    end
    tick();
    vectors++; if ({en_ram_in, en_out, busy} !== 3'b000) begin miscompares++; $display("FAIL seq_idle: got %b want 000", {en_ram_in, en_out, busy}); end
  endtask

  // Jump and fetch in the same IDLE cycle, including a target above MAX_ADDR.
  task automatic test_jump_fetch();
    logic [15:0] tgt [2];
    logic [15:0] nxt [2];
    tgt[0] = 16'd4;  nxt[0] = 16'd5;
    tgt[1] = 16'd15; nxt[1] = 16'd0;
    for (int k = 0; k < 2; k++) begin
      en_in = 1'b1; jmp_en = 1'b1; jmp_addr = tgt[k];
      tick();
      en_in = 1'b0; jmp_en = 1'b0;
      vectors++; if (addr !== tgt[k] || en_ram_in !== 1'b1) begin miscompares++; $display("FAIL jf_addr[%0d]: got %h/%b want %h/1", k, addr, en_ram_in, tgt[k]); end
      vectors++; if (pc !== tgt[k]) begin miscompares++; $display("FAIL jf_pc_load[%0d]: got %h want %h", k, pc, tgt[k]); end
      tick();
      tick();
      vectors++; if (en_out !== 1'b1 || ins !== ram_val(tgt[k])) begin miscompares++; $display("FAIL jf_ins[%0d]: got %b/%h want 1/%h", k, en_out, ins, ram_val(tgt[k])); end
      vectors++; if (pc !== nxt[k]) begin miscompares++; $display("FAIL jf_pc_next[%0d]: got %h want %h", k, pc, nxt[k]); end
      tick();
    end
  endtask

  // Jumps mid-fetch: stored in REQ, overwritten in WAIT (last wins); then a jump on the exit edge.
  task automatic test_pending_jump();
    jmp_en = 1'b1; jmp_addr = 16'd4;
    tick();
    jmp_en = 1'b0;
    vectors++; if (pc !== 16'd4 || busy !== 1'b0) begin miscompares++; $display("FAIL pj_idle_jump: got %h/%b want 0004/0", pc, busy); end
    ram_delay = 1;
    en_in = 1'b1;
    tick();
    en_in = 1'b0; jmp_en = 1'b1; jmp_addr = 16'd1;
    tick();
    jmp_addr = 16'd2;
    tick();
    jmp_en = 1'b0;
    vectors++; if (en_out !== 1'b0 || pc !== 16'd4) begin miscompares++; $display("FAIL pj_mid: got %b/%h want 0/0004", en_out, pc); end
    tick();
    vectors++; if (en_out !== 1'b1 || ins !== ram_val(16'd4)) begin miscompares++; $display("FAIL pj_ins: got %b/%h want 1/%h", en_out, ins, ram_val(16'd4)); end
    vectors++; if (pc !== 16'd2) begin miscompares++; $display("FAIL pj_pc_last_wins: got %h want 0002", pc); end
    tick();
    ram_delay = 0;
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    jmp_en = 1'b1; jmp_addr = 16'd7;
    tick();
    jmp_en = 1'b0;
    vectors++; if (en_out !== 1'b1 || ins !== ram_val(16'd2)) begin miscompares++; $display("FAIL pj_exit_ins: got %b/%h want 1/%h", en_out, ins, ram_val(16'd2)); end
    vectors++; if (pc !== 16'd7) begin miscompares++; $display("FAIL pj_exit_pc: got %h want 0007", pc); end
    tick();
  endtask

  // Ram never acks: err after 8 WAIT cycles, pc unchanged; retry clears err.
  task automatic test_timeout();
    ram_on = 1'b0;
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_wait[%0d]: got err=%b busy=%b want 0/1", c, err, busy); end
    end
    tick();
    vectors++; if ({err, busy, en_out} !== 3'b100) begin miscompares++; $display("FAIL to_err: got %b want 100", {err, busy, en_out}); end
    vectors++; if (pc !== 16'd7 || ins !== ram_val(16'd2)) begin miscompares++; $display("FAIL to_hold: got %h/%h want 0007/%h", pc, ins, ram_val(16'd2)); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", err); end
    ram_on = 1'b1;
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    vectors++; if (err !== 1'b0 || addr !== 16'd7 || en_ram_in !== 1'b1) begin miscompares++; $display("FAIL to_retry: got %b/%h/%b want 0/0007/1", err, addr, en_ram_in); end
    tick();
    tick();
    vectors++; if (en_out !== 1'b1 || ins !== ram_val(16'd7) || pc !== 16'd8) begin miscompares++; $display("FAIL to_refetch: got %b/%h/%h want 1/%h/0008", en_out, ins, pc, ram_val(16'd7)); end
    tick();
  endtask

  // Reset asserted in WAIT acts without a clock edge; the late ack is ignored.
  task automatic test_reset_mid();
    ram_delay = 1;
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    vectors++; if (pc !== 16'd0 || addr !== 16'd0) begin miscompares++; $display("FAIL rm_pc_addr: got %h/%h want 0000/0000", pc, addr); end
    vectors++; if ({en_ram_in, en_out, busy, err} !== 4'b0000 || ins !== 16'd0) begin miscompares++; $display("FAIL rm_outs: got %b/%h want 0000/0000", {en_ram_in, en_out, busy, err}, ins); end
    #2 rst = 1'b1;
    tick();
    tick();
    vectors++; if ({en_out, busy, en_ram_in} !== 3'b000 || ins !== 16'd0 || pc !== 16'd0) begin miscompares++; $display("FAIL rm_late_ack: got %b/%h/%h want 000/0000/0000", {en_out, busy, en_ram_in}, ins, pc); end
    tick();
    ram_delay = 0;
  endtask

  // Spurious ack in IDLE and en_in pulse in WAIT must not cause extra activity.
  task automatic test_spurious();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    vectors++; if ({en_out, busy, en_ram_in} !== 3'b000 || ins !== 16'd0) begin miscompares++; $display("FAIL sp_idle_ack: got %b/%h want 000/0000", {en_out, busy, en_ram_in}, ins); end
    ram_delay = 1;
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    vectors++; if (en_out !== 1'b1 || ins !== ram_val(16'd0) || pc !== 16'd1) begin miscompares++; $display("FAIL sp_fetch: got %b/%h/%h want 1/%h/0001", en_out, ins, pc, ram_val(16'd0)); end
    tick();
    vectors++; if ({en_out, busy, en_ram_in} !== 3'b000) begin miscompares++; $display("FAIL sp_no_queue: got %b want 000", {en_out, busy, en_ram_in}); end
    ram_delay = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_fetch();
    test_pending_jump();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
